counter_step_arbiter: RTL

//  Shares one 4-bit up/down counter (inc/dec step interface) between NUM_REQ requesters.

---
 rtl/counter_step_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/counter_step_arbiter.sv
// counter_step_arbiter
// Shares one up/down counter (inc/dec step interface) between NUM_REQ requesters.
// One step request is granted at a time in round-robin order. The chosen step is
// turned into a one-cycle inc or dec strobe. When SATURATE is set, a step that
// would wrap the counter is refused with nack and no strobe is issued.
// Each step takes IDLE -> STEP -> SETTLE -> IDLE. The SETTLE cycle gives the
// counter time to update before the next arbitration samples count_in.

module counter_step_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = 4,
    parameter int SATURATE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] req_up,
    input  logic [WIDTH-1:0]   count_in,
    output logic [NUM_REQ-1:0] gnt,
    output logic               nack,
    output logic               inc,
    output logic               dec,
    output logic               busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP   = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;

    // Round-robin pointer: the requester that is scanned first at the next arbitration.
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_ptr_next;

    // Arbitration results for the current cycle.
    logic               found;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   scan_idx;
    int                 scan_sum;
    logic               win_up;
    logic               sat;

    // Next values of the registered outputs.
    logic [NUM_REQ-1:0] gnt_next;
    logic               nack_next;
    logic               inc_next;
    logic               dec_next;
    logic               busy_next;

    // Find the first set request, scanning upward from rr_ptr and wrapping at NUM_REQ.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves
        // it unassigned and no latch is inferred.
        found    = 1'b0;
        winner   = '0;
        scan_sum = 0;
        scan_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_sum = int'(rr_ptr) + i;
            if (scan_sum >= NUM_REQ) begin
                scan_sum = scan_sum - NUM_REQ;
            end
            scan_idx = PTR_W'(scan_sum);
            if (!found && req[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
    end

    // Direction of the winning request, its saturation test, and the pointer advance.
    always_comb begin
        win_up = req_up[winner];
        if (win_up) begin
            sat = (count_in == {WIDTH{1'b1}});
        end else begin
            sat = (count_in == '0);
        end
        if (winner == LAST_IDX) begin
            rr_ptr_next = '0;
        end else begin
            rr_ptr_next = winner + PTR_W'(1);
        end
    end

    // State register and round-robin pointer; both return to their start on reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the values from before this edge, whatever the statement order.
        if (reset) begin
            state  <= IDLE;
            rr_ptr <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && found) begin
                rr_ptr <= rr_ptr_next;
            end
        end
    end

    // Next-state logic: one arbitration, then one strobe cycle, then one settle cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (found) next_state = STEP;
            STEP:    next_state = SETTLE;
            SETTLE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: work out what the registered outputs show in the next cycle.
    always_comb begin
        gnt_next  = '0;
        nack_next = 1'b0;
        inc_next  = 1'b0;
        dec_next  = 1'b0;
        busy_next = (next_state != IDLE);
        if (state == IDLE && found) begin
            gnt_next[winner] = 1'b1;
            if (SATURATE != 0 && sat) begin
                // The step would wrap the counter: refuse it and issue no strobe.
                nack_next = 1'b1;
            end else begin
                inc_next = win_up;
                dec_next = !win_up;
            end
        end
    end

    // Output registers. Reset drops any strobe that was already registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt  <= '0;
            nack <= 1'b0;
            inc  <= 1'b0;
            dec  <= 1'b0;
            busy <= 1'b0;
        end else begin
            gnt  <= gnt_next;
            nack <= nack_next;
            inc  <= inc_next;
            dec  <= dec_next;
            busy <= busy_next;
        end
    end

endmodule
